// File: rtl/traffic_pkg.sv
// traffic_pkg: constants shared by the traffic-controller datapath blocks.
// Holds the default lane mux geometry, the mode encodings and the grant
// counter width used when LANE_RR_MUX_STATS_EN is defined.
package traffic_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;
  localparam int CNT_W        = 16;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/lane_rr_mux_rr_arbiter.sv
// rr_arbiter: stateless rotating-priority arbiter.
// Grants the first requesting channel at or after ptr, scanning upward and
// wrapping modulo CHANNELS. The pointer itself lives in the caller.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  localparam int CW = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       ptr,
  input  logic                enable,
  output logic [CHANNELS-1:0] grant,
  output logic [CW-1:0]       grant_idx
);

  // Scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    int ch;
    grant     = '0;
    grant_idx = '0;
    ch        = 0;
    if (enable) begin
      for (int off = 0; off < CHANNELS; off++) begin
        ch = int'(ptr) + off;
        if (ch >= CHANNELS) ch = ch - CHANNELS;
        if ((grant == '0) && req[ch]) begin
          grant[ch] = 1'b1;
          grant_idx = CW'(ch);
        end
      end
    end
  end

endmodule

// File: rtl/lane_rr_mux.sv
// lane_rr_mux: N-channel registered mux with valid/ready on every port.
// Selects round-robin or a fixed channel, holds one word in an output
// register and tags it with its source channel. Define LANE_RR_MUX_STATS_EN
// to add per-channel saturating grant counters and the cnt_sel/cnt_out ports.
module lane_rr_mux
  import traffic_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int CW = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      mode,
  input  logic [CW-1:0]             fixed_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan
`ifdef LANE_RR_MUX_STATS_EN
  ,
  input  logic [CW-1:0]             cnt_sel,
  output logic [CNT_W-1:0]          cnt_out
`endif
);

  out_state_e state_q, state_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]       out_chan_q, out_chan_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       grant_idx;
  logic                can_load;
  logic                load;

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign can_load  = !out_valid || out_ready;
  assign in_ready  = grant;
  assign load      = |grant;

  // In fixed mode only fixed_sel may request; an out-of-range select matches nothing.
  always_comb begin
    req = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode == MODE_FIXED) req[i] = in_valid[i] && (int'(fixed_sel) == i);
      else                    req[i] = in_valid[i];
    end
  end

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .enable    (can_load),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Output register next state: load wins over drain so load+drain streams.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    ptr_d      = ptr_q;
    if (load) begin
      state_d    = ST_FULL;
      out_data_d = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_chan_d = grant_idx;
      if (mode == MODE_RR) begin
        ptr_d = (grant_idx == CW'(CHANNELS-1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State, held word and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      ptr_q      <= ptr_d;
    end
  end

`ifdef LANE_RR_MUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];

  // Each channel's counter steps on its own transfer and sticks at all-ones.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  // Grant counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Combinational readback of the selected counter.
  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < CHANNELS) cnt_out = cnt_q[cnt_sel];
  end
`endif

endmodule

// File: tb/tb_lane_rr_mux.sv
// Directed bench for lane_rr_mux with WIDTH=8, CHANNELS=4.
// A table of per-cycle vectors covers round-robin, skip/wrap, fixed mode and
// backpressure; hand-written sequences cover reset and async mid-run reset.
module tb_lane_rr_mux;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CW       = 2;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      mode;
  logic [CW-1:0]             fixed_sel;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [CW-1:0]             out_chan;
`ifdef LANE_RR_MUX_STATS_EN
  logic [CW-1:0]             cnt_sel;
  logic [15:0]               cnt_out;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  lane_rr_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .fixed_sel (fixed_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
`ifdef LANE_RR_MUX_STATS_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out)
`endif
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        mode;
    logic [1:0]  fixed_sel;
    logic        out_ready;
    logic [3:0]  exp_in_ready;
    logic        exp_out_valid;
    logic [7:0]  exp_out_data;
    logic [1:0]  exp_out_chan;
  } vec_t;

  localparam logic [31:0] D_STD = 32'h09_07_05_0F;
  localparam logic [31:0] D_A5  = 32'h09_A5_05_0F;

  vec_t vecs [26];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid  = v.in_valid;
    in_data   = v.in_data;
    mode      = v.mode;
    fixed_sel = v.fixed_sel;
    out_ready = v.out_ready;
  endtask

  function automatic vec_t mk(input logic [3:0] iv, input logic [31:0] d, input logic m,
                              input logic [1:0] fs, input logic ordy, input logic [3:0] eir,
                              input logic eov, input logic [7:0] eod, input logic [1:0] eoc);
    vec_t v;
    v.in_valid = iv; v.in_data = d; v.mode = m; v.fixed_sel = fs; v.out_ready = ordy;
    v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_out_data = eod; v.exp_out_chan = eoc;
    return v;
  endfunction

  initial begin
    // Round-robin fairness from ptr=0.
    vecs[0]  = mk(4'b1111, D_STD, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'd15, 2'd0);
    vecs[1]  = mk(4'b1111, D_STD, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'd5,  2'd1);
    vecs[2]  = mk(4'b1111, D_STD, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 8'd7,  2'd2);
    vecs[3]  = mk(4'b1111, D_STD, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'd9,  2'd3);
    vecs[4]  = mk(4'b1111, D_STD, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'd15, 2'd0);
    // Skip and wrap with channels 1 and 3 only.
    vecs[5]  = mk(4'b1010, D_STD, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'd5,  2'd1);
    vecs[6]  = mk(4'b1010, D_STD, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'd9,  2'd3);
    vecs[7]  = mk(4'b1010, D_STD, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'd5,  2'd1);
    vecs[8]  = mk(4'b1010, D_STD, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'd9,  2'd3);
    vecs[9]  = mk(4'b0000, D_STD, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 8'd9,  2'd3);
    // Fixed mode on channel 2; ptr stays at 0.
    vecs[10] = mk(4'b1111, D_STD, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 8'd7,  2'd2);
    vecs[11] = mk(4'b1111, D_STD, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 8'd7,  2'd2);
    vecs[12] = mk(4'b1011, D_STD, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 8'd7,  2'd2);
    vecs[13] = mk(4'b1111, D_STD, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'd15, 2'd0);
    vecs[14] = mk(4'b1111, D_STD, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'd15, 2'd0);
    vecs[15] = mk(4'b0000, D_STD, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 8'd15, 2'd0);
    // Backpressure: ch2=A5 held for 5 stalled cycles, then one drain+load.
    vecs[16] = mk(4'b0100, D_A5,  1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2);
    vecs[17] = mk(4'b1111, D_A5,  1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2);
    vecs[18] = mk(4'b1111, D_A5,  1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2);
    vecs[19] = mk(4'b1111, D_A5,  1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2);
    vecs[20] = mk(4'b1111, D_A5,  1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2);
    vecs[21] = mk(4'b1111, D_A5,  1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2);
    vecs[22] = mk(4'b1111, D_A5,  1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'd9,  2'd3);
    // fixed_sel/mode change while FULL leaves the held word alone.
    vecs[23] = mk(4'b1111, D_A5,  1'b1, 2'd1, 1'b0, 4'b0000, 1'b1, 8'd9,  2'd3);
    vecs[24] = mk(4'b1111, D_A5,  1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 8'd5,  2'd1);
    vecs[25] = mk(4'b0000, D_A5,  1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 8'd5,  2'd1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    mode      = 1'b0;
    fixed_sel = '0;
    out_ready = 1'b0;
`ifdef LANE_RR_MUX_STATS_EN
    cnt_sel   = 2'd1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data",  32'(out_data),  32'd0);
    checkOutput("reset out_chan",  32'(out_chan),  32'd0);
    checkOutput("reset in_ready",  32'(in_ready),  32'd0);
`ifdef LANE_RR_MUX_STATS_EN
    checkOutput("reset cnt_out",   32'(cnt_out),   32'd0);
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_valid));
      checkOutput($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_out_data));
      checkOutput($sformatf("v%0d out_chan", i),  32'(out_chan),  32'(vecs[i].exp_out_chan));
    end

`ifdef LANE_RR_MUX_STATS_EN
    // Channel 1 was granted in vectors 1, 5, 7 and 24.
    checkOutput("cnt ch1", 32'(cnt_out), 32'd4);
`endif

    // Load ch1 (ptr 0 -> 1 is first valid), moving ptr to 2, then reset mid-cycle.
    in_valid = 4'b0010; in_data = D_STD; mode = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
    checkOutput("pre-reset out_data",  32'(out_data),  32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset out_data",  32'(out_data),  32'd0);
    checkOutput("async reset out_chan",  32'(out_chan),  32'd0);
`ifdef LANE_RR_MUX_STATS_EN
    checkOutput("async reset cnt_out",   32'(cnt_out),   32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // First grant after reset must start from channel 0.
    in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    checkOutput("post-reset out_chan", 32'(out_chan), 32'd0);
    checkOutput("post-reset out_data", 32'(out_data), 32'd15);
    in_valid = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("final drain out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/lane_rr_mux.md
# lane_rr_mux

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It supersedes the plain 2:1 combinational mux in the traffic-controller datapath. It funnels lane-sensor words from CHANNELS sources into one consumer (the phase controller), selecting either round-robin or a fixed channel, and tags each word with its source channel.

## Interface
- WIDTH, 8, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2); CW = $clog2(CHANNELS)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  per-channel ready (one-hot or zero)
- in_data  in  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- mode  in  1  0 = round-robin, 1 = fixed select
- fixed_sel  in  CW  channel used when mode=1
- out_valid  out  1  output word held valid
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  registered selected word
- out_chan  out  CW  source channel of out_data
- cnt_sel  in  CW  channel whose grant count is shown (only with LANE_RR_MUX_STATS_EN)
- cnt_out  out  16  grant count of cnt_sel (only with LANE_RR_MUX_STATS_EN)

## Operation
- One-entry output register. State: EMPTY (out_valid=0) / FULL (out_valid=1).
- can_load = !out_valid | out_ready.
- Round-robin (mode=0): among asserted in_valid, grant the first channel at or after the priority pointer ptr, scanning upward modulo CHANNELS. On a grant to channel g, ptr <= (g+1) mod CHANNELS. ptr does not change when there is no grant.
- Fixed (mode=1): candidate is fixed_sel only. fixed_sel ≥ CHANNELS grants nothing. ptr is unchanged in this mode.
- in_ready[g] = 1 only for the granted channel and only when can_load. All other in_ready bits are 0, combinational from in_valid, mode, fixed_sel, ptr and out_valid/out_ready.
- Transfer on input g when in_valid[g] & in_ready[g]. On the next edge, out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- Output transfer when out_valid & out_ready. With no simultaneous load, out_valid <= 0. A simultaneous load and drain gives back-to-back throughput of 1 word/cycle.
- While FULL and !out_ready: out_data and out_chan are stable, and all in_ready are 0.
- A mode or fixed_sel change while FULL does not affect the held word. It applies from the next grant decision.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0, in_ready=0 (follows from out_valid=0 only when no in_valid), cnt_out=0.
- Input-to-output latency: 1 cycle.
- Reset asserted mid-operation: the held word is discarded immediately and all state returns to reset values asynchronously. The first grant after deassertion starts from channel 0.
- ptr wrap: a grant to channel CHANNELS-1 sets ptr=0.
- All in_valid low: no grant, ptr holds. out_valid falls after drain.

## Configuration
- LANE_RR_MUX_STATS_EN defined: one 16-bit saturating grant counter per channel, incremented on each input transfer for that channel. The counter holds at 16'hFFFF and clears on reset. cnt_out = counter[cnt_sel], combinational.
- LANE_RR_MUX_STATS_EN undefined: no counters, cnt_sel/cnt_out ports absent, and datapath behaviour is identical.

## Structure
- Shared package traffic_pkg: default WIDTH/CHANNELS constants, MODE_RR=1'b0 / MODE_FIXED=1'b1 constants, and the 16-bit count width constant.
- One sub-module: rr_arbiter (CHANNELS-parameterised): inputs req, ptr, enable; outputs one-hot grant and encoded index. Holds no state; ptr is kept in lane_rr_mux.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4.
- Reset: hold rst_n=0, then release with all in_valid=0 -> out_valid=0, out_data=0, out_chan=0, in_ready=4'b0000.
- Round-robin fairness: in_valid=4'b1111, data {ch0..ch3}={15,5,7,9}, out_ready=1 -> out_chan sequence 0,1,2,3,0, out_data 15,5,7,9,15, one word per cycle after 1-cycle latency.
- Skip and wrap: in_valid=4'b1010, ptr=0 -> grants 1,3,1,3. ptr wraps after channel 3.
- Backpressure: load ch2=8'hA5 with out_ready=0 for 5 cycles -> out_data=8'hA5 and out_chan=2 stable, in_ready=0. Raise out_ready -> one transfer, then the next grant.
- Fixed mode: mode=1, fixed_sel=2, in_valid=4'b1111 -> only ch2 granted, ptr unchanged. fixed_sel changed while FULL -> held word unchanged.
- Reset mid-transfer: rst_n low while out_valid=1 -> out_valid=0 asynchronously, before the next edge. With LANE_RR_MUX_STATS_EN, counts read 0 and saturate at 16'hFFFF under a forced long run.
